seg_scan_scheduler: RTL and testbench
=====================================

# seg_scan_scheduler

Time-multiplexing scheduler for the four-digit common-anode seven-segment display driven by the stopwatch top level. It owns the shared segment bus, gives each digit a fixed dwell slot followed by an anti-ghosting blank gap, and applies new digit patterns only at frame boundaries through a valid/ready handshake. Upstream, the BCD decoder supplies the patterns. Downstream, the outputs connect directly to the board's anode and segment pins.

## Interface
- DWELL_CYCLES, 1000: clock cycles each digit is driven per slot; must be ≥ 1.
- BLANK_CYCLES, 16: all-off cycles after each dwell; must be ≥ 0, and 0 removes the gap.
- clk  in  1  system clock.
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low.
- frame_valid  in  1  producer offers a new frame.
- frame_data  in  32  segment patterns; [7:0] is digit 0 … [31:24] is digit 3; active-low segments.
- frame_mask  in  4  per-digit enable; bit i = 1 enables digit i. Latched together with frame_data.
- blank  in  1  forces the display off while the scan continues.
- frame_ready  out  1  combinational; the frame is accepted in any cycle where frame_valid & frame_ready.
- frame_done  out  1  combinational one-cycle pulse in the last cycle of every frame.
- an_out  out  4  registered, active-low, one-hot anode select.
- seg_out  out  8  registered, active-low segments.

## Operation
- States: IDLE, DWELL, BLANK. Internal registers:
  - 2-bit slot index `idx`
  - slot counter `cnt`, width $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1)
  - 32-bit pattern buffer and 4-bit mask buffer.
- Reset values:
  - state = IDLE, idx = 0, cnt = 0
  - buffer = 32'hFFFF_FFFF, mask buffer = 4'h0
  - an_out = 4'hF, seg_out = 8'hFF.
- IDLE:
  - frame_ready = 1 and frame_done = 0.
  - On acceptance, latch the buffers, set idx = 0 and cnt = 0, and go to DWELL.
- DWELL:
  - an_out = ~(1 << idx) if mask[idx] = 1 and blank = 0; otherwise 4'hF.
  - seg_out = buffer[idx] if the digit is enabled and not blanked; otherwise 8'hFF.
  - cnt increments each cycle. On cnt == DWELL_CYCLES-1, go to BLANK (when BLANK_CYCLES > 0) or end the slot.
- BLANK:
  - an_out = 4'hF, seg_out = 8'hFF.
  - On cnt == BLANK_CYCLES-1, end the slot.
- End of slot: cnt resets to 0 and idx wraps 3 → 0.
- Frame boundary = last cycle of slot 3 (last BLANK cycle, or last DWELL cycle when BLANK_CYCLES = 0). In that cycle:
  - frame_done = 1 and frame_ready = 1.
  - If a frame is accepted, the buffers update for the following slot 0.
  - If no frame is accepted, the old frame repeats.
  - The scheduler never returns to IDLE except through reset.
- frame_ready is 0 in all other non-IDLE cycles. The producer holds frame_valid and frame_data/frame_mask stable until accepted.
- blank affects only the output values. idx, cnt, state and the handshake are unaffected.
- A masked digit still consumes its full slot, so the frame period is constant.

## Timing
- Outputs are registered; each reflects state/blank/buffers of the previous cycle.
- Acceptance in IDLE at cycle t:
  - digit 0 is driven for cycles t+1 … t+DWELL_CYCLES
  - blank for t+DWELL_CYCLES+1 … t+DWELL_CYCLES+BLANK_CYCLES
  - digit 1 starts at t+DWELL_CYCLES+BLANK_CYCLES+1.
- Frame period = 4·(DWELL_CYCLES+BLANK_CYCLES) cycles. frame_done pulses exactly once per period.
- A frame accepted at a boundary in cycle t appears on seg_out from t+1.
- blank asserted in cycle t: an_out = 4'hF from t+1. On deassertion, outputs resume the current slot's values one cycle later.
- At most one adjacent anode transition per cycle. With BLANK_CYCLES ≥ 1, two anodes are never low in consecutive cycles without an all-off cycle between them.
- n_rst low at any time, including mid-slot or in the boundary cycle:
  - outputs immediately go to reset values
  - a frame offered in that cycle is not accepted.

## Test plan
- DWELL=4, BLANK=2, reset then frame_valid with data 32'h03_9F_25_0D, mask 4'hF at cycle t:
  - frame_ready = 1 at t
  - an_out = 4'b1110, seg_out = 8'h0D over t+1…t+4; 4'hF / 8'hFF over t+5…t+6
  - an_out = 4'b1101, seg_out = 8'h25 from t+7
  - frame_done first pulses at t+24.
- New frame offered mid-frame: frame_ready stays 0 until the boundary cycle; new data is shown from slot 0 of the next frame only; the old frame is never torn.
- frame_mask = 4'b0101: an_out = 4'hF throughout the slots of digits 1 and 3, and the frame period is still 24 cycles.
- blank pulse of 3 cycles during the digit-2 dwell: outputs are off for exactly those 3 cycles (+1 lag); digit-3 slot timing is unchanged.
- BLANK=0: consecutive digit slots are back-to-back with no all-off cycle; period 16; frame_done/frame_ready fall in the last digit-3 dwell cycle.
- n_rst asserted in the boundary cycle while frame_valid = 1: an_out = 4'hF and seg_out = 8'hFF asynchronously; after release the state is IDLE with frame_ready = 1 and no frame latched.

Source files
------------

// File: rtl/seg_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: per-digit dwell slot plus blank gap,
// new patterns taken only at frame boundaries via a valid/ready handshake.
module seg_scan_scheduler #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        frame_valid,
  input  logic [31:0] frame_data,
  input  logic [3:0]  frame_mask,
  input  logic        blank,
  output logic        frame_ready,
  output logic        frame_done,
  output logic [3:0]  an_out,
  output logic [7:0]  seg_out,
  output logic [1:0]  dbg_state
);

  // Handshake: a frame transfers in any cycle with frame_valid & frame_ready;
  // ready is high in IDLE and in the last cycle of slot 3, and the producer
  // holds valid/data/mask stable until the transfer.

  localparam int  MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int  CW         = $clog2(MAX_CYCLES + 1);
  localparam bit  HAS_BLANK  = (BLANK_CYCLES > 0);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    an_d;
  logic [7:0]    seg_d;
  logic          last_dwell, last_blank, slot_end, accept;

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      buf_q   <= 32'hFFFF_FFFF;
      mask_q  <= 4'h0;
      an_out  <= 4'hF;
      seg_out <= 8'hFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      an_out  <= an_d;
      seg_out <= seg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    mask_d      = mask_q;
    an_d        = 4'hF;
    seg_d       = 8'hFF;
    last_dwell  = (state_q == S_DWELL) && (cnt_q == DWELL_LAST);
    last_blank  = (state_q == S_BLANK) && (cnt_q == BLANK_LAST);
    slot_end    = HAS_BLANK ? last_blank : last_dwell;
    frame_done  = slot_end && (idx_q == 2'd3);
    frame_ready = (state_q == S_IDLE) || frame_done;
    accept      = frame_valid && frame_ready;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_DWELL;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      S_DWELL: begin
        if (last_dwell) begin
          cnt_d = '0;
          if (HAS_BLANK) state_d = S_BLANK;
          else           idx_d   = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BLANK: begin
        if (last_blank) begin
          cnt_d   = '0;
          state_d = S_DWELL;
          idx_d   = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      buf_d  = frame_data;
      mask_d = frame_mask;
    end

    // Outputs are registered from next-cycle state so they line up with the slot.
    if ((state_d == S_DWELL) && mask_d[idx_d] && !blank) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = buf_d[{idx_d, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Self-checking bench for seg_scan_scheduler: frame-position reference model,
// randomized frames/masks/blank, directed timing, mask, BLANK=0 and reset cases.
module tb_seg_scan_scheduler;

  localparam int D  = 4;
  localparam int B  = 2;
  localparam int P  = 4 * (D + B);
  localparam int D0 = 4;
  localparam int B0 = 0;
  localparam int P0 = 4 * (D0 + B0);

  logic        clk = 1'b0;
  logic        n_rst;
  logic        frame_valid, blank;
  logic [31:0] frame_data;
  logic [3:0]  frame_mask;
  logic        frame_ready, frame_done;
  logic [3:0]  an_out;
  logic [7:0]  seg_out;
  logic [1:0]  dbg_state;

  logic        frame_valid0;
  logic [31:0] frame_data0;
  logic [3:0]  frame_mask0;
  logic        frame_ready0, frame_done0;
  logic [3:0]  an_out0;
  logic [7:0]  seg_out0;
  logic [1:0]  dbg_state0;

  always #5 clk = ~clk;

  seg_scan_scheduler #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .n_rst(n_rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_mask(frame_mask), .blank(blank), .frame_ready(frame_ready),
    .frame_done(frame_done), .an_out(an_out), .seg_out(seg_out), .dbg_state(dbg_state)
  );

  seg_scan_scheduler #(.DWELL_CYCLES(D0), .BLANK_CYCLES(B0)) dut0 (
    .clk(clk), .n_rst(n_rst), .frame_valid(frame_valid0), .frame_data(frame_data0),
    .frame_mask(frame_mask0), .blank(1'b0), .frame_ready(frame_ready0),
    .frame_done(frame_done0), .an_out(an_out0), .seg_out(seg_out0), .dbg_state(dbg_state0)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: position of the current cycle inside the frame period.
  bit          m_idle = 1'b1;
  int          m_pos  = 0;
  logic [31:0] m_data = 32'hFFFF_FFFF;
  logic [3:0]  m_mask = 4'h0;
  logic        m_blk  = 1'b0;
  logic [35:0] exp_q[$];

  function automatic logic [3:0] slot_an(int pos, int d, int b, logic [3:0] mask, logic blk);
    int slot = pos / (d + b);
    int off  = pos % (d + b);
    if (off < d && mask[slot] && !blk) return ~(4'b0001 << slot);
    return 4'hF;
  endfunction

  function automatic logic [7:0] slot_seg(int pos, int d, int b, logic [31:0] data,
                                          logic [3:0] mask, logic blk);
    int slot = pos / (d + b);
    int off  = pos % (d + b);
    if (off < d && mask[slot] && !blk) return data[slot*8 +: 8];
    return 8'hFF;
  endfunction

  function automatic logic [3:0] model_an();
    return m_idle ? 4'hF : slot_an(m_pos, D, B, m_mask, m_blk);
  endfunction
  function automatic logic [7:0] model_seg();
    return m_idle ? 8'hFF : slot_seg(m_pos, D, B, m_data, m_mask, m_blk);
  endfunction
  function automatic logic model_ready();
    return m_idle || (m_pos == P - 1);
  endfunction
  function automatic logic model_done();
    return !m_idle && (m_pos == P - 1);
  endfunction

  task automatic tick(output bit acc);
    logic [35:0] offered;
    logic        blk;
    acc     = n_rst && frame_valid && model_ready();
    offered = {frame_mask, frame_data};
    blk     = blank;
    @(posedge clk);
    if (acc) exp_q.push_back(offered);
    if (m_idle) begin
      if (acc) begin
        m_idle = 1'b0;
        m_pos  = 0;
        {m_mask, m_data} = exp_q.pop_front();
      end
    end else begin
      m_pos = (m_pos + 1) % P;
      if (m_pos == 0 && exp_q.size() != 0) {m_mask, m_data} = exp_q.pop_front();
    end
    m_blk = blk;
    #1;
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_pos  = 0;
    m_blk  = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit acc;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (an_out !== 4'hF) $display("FAIL reset an_out got %h want f", an_out); else n_pass++;
    n_checks++; if (seg_out !== 8'hFF) $display("FAIL reset seg_out got %h want ff", seg_out); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset state got %0d want 0", dbg_state); else n_pass++;
    n_rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (frame_ready !== 1'b1) $display("FAIL reset_idle ready got %b want 1", frame_ready); else n_pass++;
      n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_idle done got %b want 0", frame_done); else n_pass++;
      tick(acc);
      n_checks++; if (an_out !== model_an()) $display("FAIL reset_idle an_out got %h want %h", an_out, model_an()); else n_pass++;
    end
  endtask

  task automatic test_basic();
    bit acc;
    logic [3:0] ea;
    logic [7:0] es;
    frame_data  = 32'h039F_250D;
    frame_mask  = 4'hF;
    frame_valid = 1'b1;
    n_checks++; if (frame_ready !== 1'b1) $display("FAIL basic ready_t got %b want 1", frame_ready); else n_pass++;
    tick(acc);
    frame_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      ea = (c <= 4) ? 4'b1110 : (c <= 6) ? 4'hF : 4'b1101;
      es = (c <= 4) ? 8'h0D   : (c <= 6) ? 8'hFF : 8'h25;
      if (c <= 10) begin
        n_checks++; if (an_out !== ea) $display("FAIL basic an_out t+%0d got %b want %b", c, an_out, ea); else n_pass++;
        n_checks++; if (seg_out !== es) $display("FAIL basic seg_out t+%0d got %h want %h", c, seg_out, es); else n_pass++;
      end
      n_checks++; if (frame_done !== (c == 24)) $display("FAIL basic done t+%0d got %b want %b", c, frame_done, c == 24); else n_pass++;
      n_checks++; if (seg_out !== model_seg()) $display("FAIL basic model_seg got %h want %h", seg_out, model_seg()); else n_pass++;
      n_checks++; if (frame_ready !== model_ready()) $display("FAIL basic ready got %b want %b", frame_ready, model_ready()); else n_pass++;
      tick(acc);
    end
  endtask

  task automatic test_midframe();
    bit acc;
    int start;
    for (int r = 0; r < 3; r++) begin
      start = $urandom_range(0, 30);
      for (int c = 0; c < 70; c++) begin
        if (c == start) begin
          frame_data  = $urandom;
          frame_mask  = 4'hF;
          frame_valid = 1'b1;
        end
        n_checks++; if (frame_ready !== model_ready()) $display("FAIL midframe ready got %b want %b", frame_ready, model_ready()); else n_pass++;
        n_checks++; if (frame_done !== model_done()) $display("FAIL midframe done got %b want %b", frame_done, model_done()); else n_pass++;
        tick(acc);
        if (acc) frame_valid = 1'b0;
        n_checks++; if (an_out !== model_an()) $display("FAIL midframe an_out got %h want %h", an_out, model_an()); else n_pass++;
        n_checks++; if (seg_out !== model_seg()) $display("FAIL midframe seg_out got %h want %h", seg_out, model_seg()); else n_pass++;
      end
    end
  endtask

  task automatic test_blank();
    bit acc;
    bit armed = 1'b0;
    for (int c = 0; c < 3 * P; c++) begin
      if (!armed && m_pos == 11) begin
        blank = 1'b1;
        armed = 1'b1;
      end
      n_checks++; if (frame_ready !== model_ready()) $display("FAIL blank ready got %b want %b", frame_ready, model_ready()); else n_pass++;
      tick(acc);
      if (armed && m_pos == 14) blank = 1'b0;
      n_checks++; if (an_out !== model_an()) $display("FAIL blank an_out got %h want %h", an_out, model_an()); else n_pass++;
      n_checks++; if (seg_out !== model_seg()) $display("FAIL blank seg_out got %h want %h", seg_out, model_seg()); else n_pass++;
      if (armed && m_pos >= 12 && m_pos <= 14) begin
        n_checks++; if (an_out !== 4'hF) $display("FAIL blank off pos%0d got %b want 1111", m_pos, an_out); else n_pass++;
      end
      if (armed && m_pos == 15) begin
        n_checks++; if (an_out !== 4'b1011) $display("FAIL blank resume got %b want 1011", an_out); else n_pass++;
      end
      if (armed && m_pos == 18) begin
        n_checks++; if (an_out !== 4'b0111) $display("FAIL blank digit3 got %b want 0111", an_out); else n_pass++;
        break;
      end
    end
    blank = 1'b0;
  endtask

  task automatic test_mask();
    bit acc;
    int last_done = -1;
    frame_data  = $urandom;
    frame_mask  = 4'b0101;
    frame_valid = 1'b1;
    for (int c = 0; c < 3 * P; c++) begin
      if (frame_done === 1'b1) begin
        if (last_done >= 0) begin
          n_checks++; if (c - last_done != P) $display("FAIL mask period got %0d want %0d", c - last_done, P); else n_pass++;
        end
        last_done = c;
      end
      n_checks++; if (frame_done !== model_done()) $display("FAIL mask done got %b want %b", frame_done, model_done()); else n_pass++;
      tick(acc);
      if (acc) frame_valid = 1'b0;
      n_checks++; if (an_out !== model_an()) $display("FAIL mask an_out got %h want %h", an_out, model_an()); else n_pass++;
      n_checks++; if (seg_out !== model_seg()) $display("FAIL mask seg_out got %h want %h", seg_out, model_seg()); else n_pass++;
      if (!frame_valid && (m_pos / (D + B) == 1 || m_pos / (D + B) == 3)) begin
        n_checks++; if (an_out !== 4'hF) $display("FAIL mask disabled an_out got %b want 1111", an_out); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) blank = ~blank;
      if (!frame_valid && $urandom_range(0, 9) == 0) begin
        frame_data  = $urandom;
        frame_mask  = 4'($urandom_range(0, 15));
        frame_valid = 1'b1;
      end
      n_checks++; if (frame_ready !== model_ready()) $display("FAIL random ready got %b want %b", frame_ready, model_ready()); else n_pass++;
      n_checks++; if (frame_done !== model_done()) $display("FAIL random done got %b want %b", frame_done, model_done()); else n_pass++;
      tick(acc);
      if (acc) frame_valid = 1'b0;
      n_checks++; if (an_out !== model_an()) $display("FAIL random an_out got %h want %h", an_out, model_an()); else n_pass++;
      n_checks++; if (seg_out !== model_seg()) $display("FAIL random seg_out got %h want %h", seg_out, model_seg()); else n_pass++;
    end
    frame_valid = 1'b0;
    blank       = 1'b0;
  endtask

  task automatic test_blank0();
    bit acc;
    int pos;
    logic [31:0] data0;
    data0        = $urandom;
    frame_data0  = data0;
    frame_mask0  = 4'hF;
    frame_valid0 = 1'b1;
    n_checks++; if (frame_ready0 !== 1'b1) $display("FAIL blank0 ready_idle got %b want 1", frame_ready0); else n_pass++;
    tick(acc);
    frame_valid0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pos = i % P0;
      n_checks++; if (frame_done0 !== (pos == P0 - 1)) $display("FAIL blank0 done pos%0d got %b want %b", pos, frame_done0, pos == P0 - 1); else n_pass++;
      n_checks++; if (frame_ready0 !== (pos == P0 - 1)) $display("FAIL blank0 ready pos%0d got %b want %b", pos, frame_ready0, pos == P0 - 1); else n_pass++;
      n_checks++; if (an_out0 !== slot_an(pos, D0, B0, 4'hF, 1'b0)) $display("FAIL blank0 an_out pos%0d got %b want %b", pos, an_out0, slot_an(pos, D0, B0, 4'hF, 1'b0)); else n_pass++;
      n_checks++; if (seg_out0 !== slot_seg(pos, D0, B0, data0, 4'hF, 1'b0)) $display("FAIL blank0 seg_out pos%0d got %h want %h", pos, seg_out0, slot_seg(pos, D0, B0, data0, 4'hF, 1'b0)); else n_pass++;
      tick(acc);
    end
  endtask

  task automatic test_reset_boundary();
    bit acc;
    logic [31:0] fresh;
    // Clean start, then a reset in the middle of the digit-0 dwell.
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    model_reset();
    frame_data  = 32'h1234_5678;
    frame_mask  = 4'hF;
    frame_valid = 1'b1;
    tick(acc);
    frame_valid = 1'b0;
    tick(acc);
    n_checks++; if (an_out !== 4'b1110) $display("FAIL rst_mid pre an_out got %b want 1110", an_out); else n_pass++;
    #2 n_rst = 1'b0;
    #1;
    n_checks++; if (an_out !== 4'hF) $display("FAIL rst_mid async an_out got %h want f", an_out); else n_pass++;
    n_checks++; if (seg_out !== 8'hFF) $display("FAIL rst_mid async seg_out got %h want ff", seg_out); else n_pass++;
    @(posedge clk); #1;
    n_rst = 1'b1;
    model_reset();
    // Run a new frame up to its boundary cycle and reset there with a frame offered.
    frame_data  = $urandom;
    frame_valid = 1'b1;
    tick(acc);
    frame_valid = 1'b0;
    for (int c = 0; c < 2 * P && m_pos != P - 2; c++) tick(acc);
    frame_data  = 32'hA5A5_A5A5;
    frame_mask  = 4'hF;
    frame_valid = 1'b1;
    tick(acc);
    n_checks++; if (frame_ready !== 1'b1) $display("FAIL rst_bnd ready got %b want 1", frame_ready); else n_pass++;
    #2 n_rst = 1'b0;
    #1;
    n_checks++; if (an_out !== 4'hF) $display("FAIL rst_bnd async an_out got %h want f", an_out); else n_pass++;
    n_checks++; if (seg_out !== 8'hFF) $display("FAIL rst_bnd async seg_out got %h want ff", seg_out); else n_pass++;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    n_rst = 1'b1;
    model_reset();
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL rst_bnd state got %0d want 0", dbg_state); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (frame_ready !== 1'b1) $display("FAIL rst_bnd idle ready got %b want 1", frame_ready); else n_pass++;
      tick(acc);
      n_checks++; if (an_out !== 4'hF) $display("FAIL rst_bnd idle an_out got %h want f", an_out); else n_pass++;
      n_checks++; if (seg_out !== 8'hFF) $display("FAIL rst_bnd idle seg_out got %h want ff", seg_out); else n_pass++;
    end
    fresh       = $urandom;
    frame_data  = fresh;
    frame_valid = 1'b1;
    tick(acc);
    frame_valid = 1'b0;
    n_checks++; if (seg_out !== fresh[7:0]) $display("FAIL rst_bnd fresh seg_out got %h want %h", seg_out, fresh[7:0]); else n_pass++;
    for (int c = 0; c < 30; c++) begin
      tick(acc);
      n_checks++; if (seg_out !== model_seg()) $display("FAIL rst_bnd run seg_out got %h want %h", seg_out, model_seg()); else n_pass++;
    end
  endtask

  initial begin
    frame_valid  = 1'b0;
    frame_data   = '0;
    frame_mask   = '0;
    blank        = 1'b0;
    frame_valid0 = 1'b0;
    frame_data0  = '0;
    frame_mask0  = '0;
    test_reset();
    test_basic();
    test_midframe();
    test_blank();
    test_mask();
    test_random();
    test_blank0();
    test_reset_boundary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout after %0d checks", n_checks);
    $fatal(1);
  end

endmodule
